// File: rtl/phy_pkg.sv
// ---------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the receive-side symbol path.
//   SIZE_DEFAULT      : default symbol width (8b/10b => 10 bits)
//   K285_RDN/K285_RDP : the two disparity forms of the K28.5 comma
//   align_state_t     : states of the symbol alignment FSM
//   is_k285()         : true when a 10-bit window holds either comma form
// ---------------------------------------------------------------------------
package phy_pkg;

    localparam int SIZE_DEFAULT = 10;

    localparam logic [9:0] K285_RDN = 10'h17C;
    localparam logic [9:0] K285_RDP = 10'h283;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    function automatic logic is_k285(input logic [9:0] win);
        return (win == K285_RDN) || (win == K285_RDP);
    endfunction

endpackage

// File: rtl/rx_shift10.sv
// ---------------------------------------------------------------------------
// rx_shift10
// Serial-in shift register holding the last SIZE received bits, plus the
// K28.5 comparator on the registered window.
//   clk    : bit clock, one serial bit per rising edge
//   rst_n  : asynchronous active-low reset, clears the window
//   data   : serial input bit
//   window : last SIZE bits; bit 0 is the oldest, bit SIZE-1 the newest
//   match  : window currently holds a K28.5 of either disparity
// ---------------------------------------------------------------------------
module rx_shift10
    import phy_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data,
    output logic [SIZE-1:0] window,
    output logic            match
);

    logic [SIZE-1:0] window_reg;
    logic [SIZE-1:0] window_next;

    // Bits move toward bit 0; the newest bit always lands in the top bit so
    // that a fully received symbol reads naturally with bit a at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < SIZE - 1; gi++) begin : g_shift
            assign window_next[gi] = window_reg[gi+1];
        end
    endgenerate
    assign window_next[SIZE-1] = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_reg <= '0;
        end else begin
            window_reg <= window_next;
        end
    end

    assign window = window_reg;
    assign match  = is_k285(window_reg);

endmodule

// File: rtl/rx_symbol_aligner.sv
// ---------------------------------------------------------------------------
// rx_symbol_aligner
// Deserialises the recovered bit stream, hunts for K28.5 commas, confirms the
// symbol phase over LOCK_COMMAS commas and then emits one aligned symbol every
// SIZE clocks. Lock is lost after MISALIGN_LIMIT misaligned commas or on
// electrical idle.
//   TRANSCLK        : bit clock
//   RESET_N         : asynchronous active-low reset
//   data            : serial receive bit
//   RXIDLE          : electrical idle, overrides everything
//   SYMBOL          : aligned symbol, bit 0 = first received bit
//   SYMBOL_VALID    : one-cycle strobe with each new SYMBOL
//   SYMBOL_IS_COMMA : SYMBOL is a K28.5 (qualified by SYMBOL_VALID)
//   RXVALID         : high while locked
// ---------------------------------------------------------------------------
module rx_symbol_aligner
    import phy_pkg::*;
#(
    parameter int SIZE           = SIZE_DEFAULT,
    parameter int LOCK_COMMAS    = 2,
    parameter int MISALIGN_LIMIT = 2
) (
    input  logic            TRANSCLK,
    input  logic            RESET_N,
    input  logic            data,
    input  logic            RXIDLE,
    output logic [SIZE-1:0] SYMBOL,
    output logic            SYMBOL_VALID,
    output logic            SYMBOL_IS_COMMA,
    output logic            RXVALID
);

    localparam logic [2:0] LOCK_TARGET  = 3'(LOCK_COMMAS);
    localparam logic [2:0] MIS_TARGET   = 3'(MISALIGN_LIMIT);
    localparam logic [3:0] PHASE_LAST   = 4'(SIZE - 1);

    logic [SIZE-1:0] window;
    logic            match;

    rx_shift10 #(.SIZE(SIZE)) u_shift (
        .clk    (TRANSCLK),
        .rst_n  (RESET_N),
        .data   (data),
        .window (window),
        .match  (match)
    );

    align_state_t    state_reg, state_next;
    logic [3:0]      phase_reg, phase_next;
    logic [2:0]      comma_cnt_reg, comma_cnt_next;
    logic [2:0]      misalign_cnt_reg, misalign_cnt_next;
    logic [SIZE-1:0] symbol_reg, symbol_next;
    logic            symbol_valid_reg, symbol_valid_next;
    logic            symbol_is_comma_reg, symbol_is_comma_next;
    logic            rxvalid_reg, rxvalid_next;
    logic            boundary;
    logic            realign;
    logic            emit;

    assign boundary = (phase_reg == 4'd0);

    always_comb begin
        state_next           = state_reg;
        comma_cnt_next       = comma_cnt_reg;
        misalign_cnt_next    = misalign_cnt_reg;
        symbol_next          = symbol_reg;
        symbol_is_comma_next = symbol_is_comma_reg;
        symbol_valid_next    = 1'b0;
        realign              = 1'b0;
        emit                 = 1'b0;

        if (RXIDLE) begin
            state_next        = HUNT;
            comma_cnt_next    = 3'd0;
            misalign_cnt_next = 3'd0;
        end else begin
            case (state_reg)
                HUNT: begin
                    if (match) begin
                        realign        = 1'b1;
                        comma_cnt_next = 3'd1;
                        if (LOCK_TARGET == 3'd1) begin
                            state_next = LOCKED;
                            emit       = 1'b1;
                        end else begin
                            state_next = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (match && boundary) begin
                        // Count stops at the target: reaching it leaves CONFIRM.
                        comma_cnt_next = comma_cnt_reg + 3'd1;
                        if (comma_cnt_reg + 3'd1 >= LOCK_TARGET) begin
                            comma_cnt_next = LOCK_TARGET;
                            state_next     = LOCKED;
                            emit           = 1'b1;
                        end
                    end else if (match) begin
                        // Comma at a new phase restarts the confirmation there.
                        realign        = 1'b1;
                        comma_cnt_next = 3'd1;
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        emit = 1'b1;
                        if (match) begin
                            misalign_cnt_next = 3'd0;
                        end
                    end else if (match) begin
                        // Stay on the established phase; only count the offence.
                        if (misalign_cnt_reg + 3'd1 >= MIS_TARGET) begin
                            state_next        = HUNT;
                            comma_cnt_next    = 3'd0;
                            misalign_cnt_next = 3'd0;
                        end else begin
                            misalign_cnt_next = misalign_cnt_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end

        if (emit) begin
            symbol_next          = window;
            symbol_is_comma_next = match;
            symbol_valid_next    = 1'b1;
        end

        // Realign makes the match cycle the boundary: the next cycle is phase 1.
        if (realign) begin
            phase_next = 4'd1;
        end else if (phase_reg == PHASE_LAST) begin
            phase_next = 4'd0;
        end else begin
            phase_next = phase_reg + 4'd1;
        end

        rxvalid_next = (state_next == LOCKED);
    end

    always_ff @(posedge TRANSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg           <= HUNT;
            phase_reg           <= 4'd0;
            comma_cnt_reg       <= 3'd0;
            misalign_cnt_reg    <= 3'd0;
            symbol_reg          <= '0;
            symbol_valid_reg    <= 1'b0;
            symbol_is_comma_reg <= 1'b0;
            rxvalid_reg         <= 1'b0;
        end else begin
            state_reg           <= state_next;
            phase_reg           <= phase_next;
            comma_cnt_reg       <= comma_cnt_next;
            misalign_cnt_reg    <= misalign_cnt_next;
            symbol_reg          <= symbol_next;
            symbol_valid_reg    <= symbol_valid_next;
            symbol_is_comma_reg <= symbol_is_comma_next;
            rxvalid_reg         <= rxvalid_next;
        end
    end

    assign SYMBOL          = symbol_reg;
    assign SYMBOL_VALID    = symbol_valid_reg;
    assign SYMBOL_IS_COMMA = symbol_is_comma_reg;
    assign RXVALID         = rxvalid_reg;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// ---------------------------------------------------------------------------
// tb_rx_symbol_aligner
// Directed bench. Bits are driven on the falling edge; on that same falling
// edge the outputs (settled since the previous rising edge) are logged under
// the index k of the bit being driven. The DUT acts on window W(k) at the
// rising edge after bit k+1 is driven, so its result is logged at index k+2.
// ---------------------------------------------------------------------------
module tb_rx_symbol_aligner;

    logic       TRANSCLK = 1'b0;
    logic       RESET_N;
    logic       data;
    logic       RXIDLE;
    logic [9:0] SYMBOL;
    logic       SYMBOL_VALID;
    logic       SYMBOL_IS_COMMA;
    logic       RXVALID;

    always #5 TRANSCLK = ~TRANSCLK;

    rx_symbol_aligner #(
        .SIZE           (10),
        .LOCK_COMMAS    (2),
        .MISALIGN_LIMIT (2)
    ) dut (
        .TRANSCLK        (TRANSCLK),
        .RESET_N         (RESET_N),
        .data            (data),
        .RXIDLE          (RXIDLE),
        .SYMBOL          (SYMBOL),
        .SYMBOL_VALID    (SYMBOL_VALID),
        .SYMBOL_IS_COMMA (SYMBOL_IS_COMMA),
        .RXVALID         (RXVALID)
    );

    localparam logic [9:0] K_RDN = 10'h17C;
    localparam logic [9:0] K_RDP = 10'h283;

    int n_compared   = 0;
    int n_mismatched = 0;
    int k;
    int idle_lo;
    int idle_hi;

    logic       lg_valid [0:511];
    logic       lg_rxv   [0:511];
    logic       lg_comma [0:511];
    logic [9:0] lg_sym   [0:511];
    logic [9:0] dsym     [0:2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("check %s: %0h ok", tag, got);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge TRANSCLK);
        lg_valid[k] = SYMBOL_VALID;
        lg_rxv[k]   = RXVALID;
        lg_comma[k] = SYMBOL_IS_COMMA;
        lg_sym[k]   = SYMBOL;
        data        = b;
        RXIDLE      = (k >= idle_lo) && (k <= idle_hi);
        k++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    function automatic int pulses(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (lg_valid[i]) n++;
        return n;
    endfunction

    function automatic int rxv_lows(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (!lg_rxv[i]) n++;
        return n;
    endfunction

    initial begin
        dsym[0] = 10'h155;   // D21.5
        dsym[1] = 10'h2AA;   // D10.2
        dsym[2] = 10'h0B9;   // D0.0 RD-
        RESET_N = 1'b0;
        data    = 1'b0;
        RXIDLE  = 1'b0;
        k       = 0;
        idle_lo = -1;
        idle_hi = -1;

        repeat (3) @(negedge TRANSCLK);
        check("rst_symbol", SYMBOL, 0);
        check("rst_valid", SYMBOL_VALID, 0);
        check("rst_comma", SYMBOL_IS_COMMA, 0);
        check("rst_rxvalid", RXVALID, 0);
        RESET_N = 1'b1;

        // ---- stimulus, first epoch ----
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);          // 3-bit slip, k=0..2
        send_sym(K_RDN); send_sym(dsym[1]); send_sym(K_RDP);     // k=3..32
        for (int i = 0; i < 20; i++) send_sym(dsym[i % 3]);      // k=33..232
        send_bit(1'b0);                                          // slip, k=233
        send_sym(K_RDN);                                         // misaligned, W(243)
        for (int i = 0; i < 9; i++) send_bit(1'(i % 2));         // back on phase, k=244..252
        send_sym(K_RDN);                                         // aligned, W(262)
        send_bit(1'b1);                                          // slip, k=263
        send_sym(K_RDN); send_sym(K_RDN);                        // W(273), W(283) misaligned
        send_sym(K_RDN); send_sym(K_RDN);                        // relock: W(293), W(303)
        send_sym(dsym[0]); send_sym(dsym[1]);                    // k=304..323
        idle_lo = 330;
        idle_hi = 334;
        send_sym(K_RDN);                                         // W(333) under idle
        send_sym(K_RDN); send_sym(K_RDN);                        // W(343), W(353)
        send_sym(dsym[0]); send_sym(dsym[1]);                    // k=354..373
        for (int i = 0; i < 5; i++) send_bit(dsym[2][i]);        // mid-symbol, k=374..378

        // ---- lock ----
        check("pre_lock_pulses", pulses(0, 33), 0);
        check("lock_rxv_before", lg_rxv[33], 0);
        check("lock_rxv_rise", lg_rxv[34], 1);
        check("lock_valid", lg_valid[34], 1);
        check("lock_symbol", lg_sym[34], K_RDP);
        check("lock_is_comma", lg_comma[34], 1);

        // ---- 20 data symbols ----
        for (int i = 0; i < 20; i++) begin
            check($sformatf("data%0d_valid", i), lg_valid[44 + 10 * i], 1);
            check($sformatf("data%0d_symbol", i), lg_sym[44 + 10 * i], dsym[i % 3]);
            check($sformatf("data%0d_comma", i), lg_comma[44 + 10 * i], 0);
        end
        check("data_pulse_count", pulses(35, 234), 20);
        check("rxv_held_lows", rxv_lows(34, 284), 0);

        // ---- misalignment ----
        check("realigned_comma_valid", lg_valid[264], 1);
        check("realigned_comma_sym", lg_sym[264], K_RDN);
        check("realigned_comma_flag", lg_comma[264], 1);
        check("one_misalign_keeps", lg_rxv[275], 1);
        check("two_misalign_drop", lg_rxv[285], 0);
        check("unlocked_pulses", pulses(286, 304), 0);
        check("relock_rxv_before", lg_rxv[304], 0);
        check("relock_rxv", lg_rxv[305], 1);
        check("relock_valid", lg_valid[305], 1);
        check("relock_symbol", lg_sym[305], K_RDN);
        check("relock_data0", lg_sym[315], dsym[0]);
        check("relock_data1", lg_sym[325], dsym[1]);
        check("relock_data1_valid", lg_valid[325], 1);

        // ---- idle ----
        check("idle_rxv_before", lg_rxv[330], 1);
        check("idle_rxv_drop", lg_rxv[331], 0);
        check("idle_pulses", pulses(331, 354), 0);
        check("idle_comma_ignored", lg_rxv[345], 0);
        check("idle_relock_rxv", lg_rxv[355], 1);
        check("idle_relock_valid", lg_valid[355], 1);
        check("idle_relock_symbol", lg_sym[355], K_RDN);
        check("post_idle_data", lg_sym[365], dsym[0]);

        // ---- async reset mid-symbol ----
        check("pre_reset_rxv", RXVALID, 1);
        check("pre_reset_symbol", SYMBOL, dsym[1]);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_symbol", SYMBOL, 0);
        check("async_valid", SYMBOL_VALID, 0);
        check("async_comma", SYMBOL_IS_COMMA, 0);
        check("async_rxvalid", RXVALID, 0);
        data    = 1'b0;
        idle_lo = -1;
        idle_hi = -1;
        repeat (2) @(negedge TRANSCLK);
        RESET_N = 1'b1;
        k = 0;
        send_sym(K_RDN); send_sym(K_RDN); send_sym(dsym[0]);
        check("post_reset_one_comma", lg_rxv[11], 0);
        check("post_reset_rxv_before", lg_rxv[20], 0);
        check("post_reset_lock", lg_rxv[21], 1);
        check("post_reset_symbol", lg_sym[21], K_RDN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
